// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
//   BITS_PER_FRAME : start + 8 data + parity + stop
//   CLKS_PER_BIT   : clk_sys cycles per UART bit
//   state_t        : frame scheduler states
//   byte_t         : one payload byte
package uart_pkg;

    localparam int BITS_PER_FRAME = 11;
    localparam int CLKS_PER_BIT   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with push/pop arbitration and a sticky overflow flag.
// Ports:
//   clk, rst      : clock, async active-high reset
//   push_i        : enqueue data_i (dropped when full unless popped same cycle)
//   data_i        : byte to enqueue
//   pop_i         : dequeue head (ignored when empty)
//   clr_ovf_i     : clear overflow
//   head_o        : byte at the read pointer
//   count_o       : bytes stored
//   full_o/empty_o: derived from registered count
//   overflow_o    : sticky, set when a push is dropped
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  byte_t                      data_i,
    input  logic                       pop_i,
    input  logic                       clr_ovf_i,
    output byte_t                      head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    byte_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q;
    logic           do_pop, do_push, drop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign head_o     = mem_q[rd_ptr_q];

    // A simultaneous pop frees the slot, so a push into a full queue is
    // still accepted in that cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop    = push_i && !do_push;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            // A dropped push wins over a clear in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and frame scheduler feeding uart_tx. Each queued byte is
// presented on tx_data with an EN_CYCLES-long tx_en strobe, then the block
// waits out FRAME_CYCLES before popping the next byte.
// Ports:
//   clk, rst : clock, async active-high reset
//   push     : enqueue data_in
//   data_in  : byte to enqueue
//   clr_ovf  : clear sticky overflow
//   tx_data  : byte to uart_tx (registered, held between frames)
//   tx_en    : enable to uart_tx (registered)
//   busy     : frame in progress
//   count    : bytes queued, excluding the one in flight
//   full/empty/overflow : queue status
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int EN_CYCLES    = 2,
    parameter int FRAME_CYCLES = BITS_PER_FRAME * CLKS_PER_BIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  byte_t                      data_in,
    input  logic                       clr_ovf,
    output byte_t                      tx_data,
    output logic                       tx_en,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int NW = $clog2(FRAME_CYCLES);
    localparam logic [NW-1:0] CNT_LAST = NW'(FRAME_CYCLES - 1);

    state_t         state_q;
    logic [NW-1:0]  cnt_q;
    byte_t          tx_data_q;
    logic           tx_en_q;
    byte_t          fifo_head;
    logic           pop;

    // Popping happens only in the single IDLE cycle between frames.
    assign pop = (state_q == IDLE) && !empty;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .data_i     (data_in),
        .pop_i      (pop),
        .clr_ovf_i  (clr_ovf),
        .head_o     (fifo_head),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q   <= SEND;
                        cnt_q     <= '0;
                        tx_data_q <= fifo_head;
                        tx_en_q   <= (EN_CYCLES > 0);
                    end
                end
                SEND: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        tx_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + NW'(1);
                        // tx_en mirrors the counter value that will hold after this edge.
                        tx_en_q <= ((int'(cnt_q) + 1) < EN_CYCLES);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign busy    = (state_q == SEND);

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    byte_t       data_in;
    logic        clr_ovf;
    byte_t       tx_data;
    logic        tx_en;
    logic        busy;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_queue #(.DEPTH(4), .EN_CYCLES(2), .FRAME_CYCLES(44)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  (data_in),
        .clr_ovf  (clr_ovf),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .busy     (busy),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int rises = 0;
        logic prev = 1'b0;
        rst = 1'b1; push = 1'b0; data_in = '0; clr_ovf = 1'b0;
        #1;
        tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        tests_run++; if (tx_en !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got=%b exp=0", full); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tx_en && !prev) rises++;
            prev = tx_en;
        end
        tests_run++; if (rises !== 0) begin tests_failed++; $display("FAIL idle_no_tx_en got=%0d rises exp=0", rises); end
        tests_run++; if (busy !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL idle_status got busy=%b empty=%b exp busy=0 empty=1", busy, empty); end
    endtask

    task automatic test_single();
        logic exp_en, exp_busy;
        push = 1'b1; data_in = 8'h93;
        tick();
        push = 1'b0;
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL single_count_after_push got=%0d exp=1", count); end
        tests_run++; if (tx_en !== 1'b0) begin tests_failed++; $display("FAIL single_en_after_push got=%b exp=0", tx_en); end
        for (int k = 1; k <= 47; k++) begin
            tick();
            exp_en = (k == 1 || k == 2);
            exp_busy = (k <= 44);
            tests_run++; if (tx_en !== exp_en) begin tests_failed++; $display("FAIL single_tx_en k=%0d got=%b exp=%b", k, tx_en, exp_en); end
            tests_run++; if (busy !== exp_busy) begin tests_failed++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
            tests_run++; if (tx_data !== 8'h93) begin tests_failed++; $display("FAIL single_tx_data k=%0d got=%h exp=93", k, tx_data); end
            if (k == 1) begin
                tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL single_count_after_pop got=%0d exp=0", count); end
            end
        end
    endtask

    task automatic test_back_to_back();
        byte_t seq [3];
        int    rise_t [$];
        byte_t rise_d [$];
        logic  rise_e [$];
        logic  prev = 1'b0;
        int    peak = 0;
        seq[0] = 8'hC2; seq[1] = 8'h95; seq[2] = 8'hF3;
        for (int k = 0; k < 200; k++) begin
            if (k < 3) begin push = 1'b1; data_in = seq[k]; end else push = 1'b0;
            tick();
            if (tx_en && !prev) begin rise_t.push_back(k); rise_d.push_back(tx_data); rise_e.push_back(empty); end
            prev = tx_en;
            if (int'(count) > peak) peak = int'(count);
        end
        tests_run++;
        if (rise_t.size() !== 3) begin
            tests_failed++; $display("FAIL b2b_rise_count got=%0d exp=3", rise_t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++; if (rise_t[i] !== 1 + 45 * i) begin tests_failed++; $display("FAIL b2b_rise_time i=%0d got=%0d exp=%0d", i, rise_t[i], 1 + 45 * i); end
                tests_run++; if (rise_d[i] !== seq[i]) begin tests_failed++; $display("FAIL b2b_order i=%0d got=%h exp=%h", i, rise_d[i], seq[i]); end
            end
            tests_run++; if (rise_e[2] !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty_after_third got=%b exp=1", rise_e[2]); end
        end
        tests_run++; if (peak !== 2) begin tests_failed++; $display("FAIL b2b_count_peak got=%0d exp=2", peak); end
    endtask

    task automatic test_overflow();
        byte_t rise_d [$];
        logic  prev = 1'b0;
        for (int k = 0; k < 260; k++) begin
            if (k < 6) begin push = 1'b1; data_in = byte_t'(k + 1); end else push = 1'b0;
            tick();
            if (k == 4) begin
                tests_run++; if (full !== 1'b1 || overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_before_drop got full=%b ovf=%b exp full=1 ovf=0", full, overflow); end
            end
            if (k == 5) begin
                tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count got=%0d exp=4", count); end
                tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got=%b exp=1", overflow); end
            end
            if (tx_en && !prev) rise_d.push_back(tx_data);
            prev = tx_en;
        end
        tests_run++;
        if (rise_d.size() !== 5) begin
            tests_failed++; $display("FAIL ovf_frames got=%0d exp=5", rise_d.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++; if (rise_d[i] !== byte_t'(i + 1)) begin tests_failed++; $display("FAIL ovf_order i=%0d got=%h exp=%h", i, rise_d[i], byte_t'(i + 1)); end
            end
        end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_pop();
        byte_t seq [5];
        byte_t rise_d [$];
        logic  prev = 1'b0;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55;
        for (int k = 0; k < 280; k++) begin
            if (k < 5) begin push = 1'b1; data_in = seq[k]; end
            else if (k == 46) begin push = 1'b1; data_in = 8'hAA; end
            else push = 1'b0;
            tick();
            if (k == 45) begin
                tests_run++; if (full !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL fullpop_pre got full=%b busy=%b exp full=1 busy=0", full, busy); end
            end
            if (k == 46) begin
                tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL fullpop_count got=%0d exp=4", count); end
                tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
            end
            if (tx_en && !prev) rise_d.push_back(tx_data);
            prev = tx_en;
        end
        tests_run++;
        if (rise_d.size() !== 6) begin
            tests_failed++; $display("FAIL fullpop_frames got=%0d exp=6", rise_d.size());
        end else begin
            tests_run++; if (rise_d[1] !== 8'h22) begin tests_failed++; $display("FAIL fullpop_second got=%h exp=22", rise_d[1]); end
            tests_run++; if (rise_d[5] !== 8'hAA) begin tests_failed++; $display("FAIL fullpop_last got=%h exp=aa", rise_d[5]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int   rises = 0;
        logic prev = 1'b0;
        for (int k = 0; k < 21; k++) begin
            if (k < 3) begin push = 1'b1; data_in = byte_t'(8'hB1 + k); end else push = 1'b0;
            tick();
        end
        tests_run++; if (count !== 3'd2 || busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre got count=%0d busy=%b exp count=2 busy=1", count, busy); end
        rst = 1'b1;
        #1;
        tests_run++; if (tx_en !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tx_en got=%b exp=0", tx_en); end
        tests_run++; if (count !== 3'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL rstmid_count got=%0d empty=%b exp 0/1", count, empty); end
        tests_run++; if (busy !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_state got busy=%b data=%h exp 0/00", busy, tx_data); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (tx_en && !prev) rises++;
            prev = tx_en;
        end
        tests_run++; if (rises !== 0) begin tests_failed++; $display("FAIL rstmid_no_more_frames got=%0d exp=0", rises); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
